// File: rtl/floo_dma_req_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : floo_dma_req_serializer_if
// Brief    : Wide-request / narrow-flit / response bundle of the DMA serializer.
// Revision : 1.0
// ============================================================================
interface floo_dma_req_serializer_if #(
  parameter int unsigned NUM_WORDS       = 4,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 18,
  parameter int unsigned META_WIDTH      = 8,
  parameter int unsigned MAX_OUTSTANDING = 4
);
  localparam int unsigned c_BE_W  = DATA_WIDTH / 8;
  localparam int unsigned c_CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic                            req_valid_i;
  logic                            req_ready_o;
  logic                            req_wen_i;
  logic [NUM_WORDS*c_BE_W-1:0]     req_be_i;
  logic [NUM_WORDS*DATA_WIDTH-1:0] req_data_i;
  logic [ADDR_WIDTH-1:0]           req_addr_i;
  logic [META_WIDTH-1:0]           req_meta_i;

  logic                            flit_valid_o;
  logic                            flit_ready_i;
  logic                            flit_wen_o;
  logic [c_BE_W-1:0]               flit_be_o;
  logic [DATA_WIDTH-1:0]           flit_data_o;
  logic [ADDR_WIDTH-1:0]           flit_addr_o;
  logic [META_WIDTH-1:0]           flit_meta_o;
  logic                            flit_last_o;

  logic                            rsp_valid_i;
  logic                            rsp_ready_o;
  logic [DATA_WIDTH-1:0]           rsp_data_i;

  logic                            wrsp_valid_o;
  logic                            wrsp_ready_i;
  logic [NUM_WORDS*DATA_WIDTH-1:0] wrsp_data_o;
  logic [NUM_WORDS-1:0]            wrsp_strb_o;
  logic [c_CNT_W-1:0]              outstanding_o;

  modport slave (
    input  req_valid_i, req_wen_i, req_be_i, req_data_i, req_addr_i, req_meta_i,
    output req_ready_o,
    output flit_valid_o, flit_wen_o, flit_be_o, flit_data_o, flit_addr_o,
           flit_meta_o, flit_last_o,
    input  flit_ready_i,
    input  rsp_valid_i, rsp_data_i,
    output rsp_ready_o,
    output wrsp_valid_o, wrsp_data_o, wrsp_strb_o, outstanding_o,
    input  wrsp_ready_i
  );

  modport master (
    output req_valid_i, req_wen_i, req_be_i, req_data_i, req_addr_i, req_meta_i,
    input  req_ready_o,
    input  flit_valid_o, flit_wen_o, flit_be_o, flit_data_o, flit_addr_o,
           flit_meta_o, flit_last_o,
    output flit_ready_i,
    output rsp_valid_i, rsp_data_i,
    input  rsp_ready_o,
    input  wrsp_valid_o, wrsp_data_o, wrsp_strb_o, outstanding_o,
    output wrsp_ready_i
  );
endinterface
`default_nettype wire

// File: rtl/floo_dma_req_serializer.sv
`default_nettype none
// ============================================================================
// Module   : floo_dma_req_serializer
// Brief    : Splits a wide DMA request into word flits and reassembles reads.
// Revision : 1.0
// ============================================================================
module floo_dma_req_serializer #(
  parameter int unsigned NUM_WORDS       = 4,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 18,
  parameter int unsigned META_WIDTH      = 8,
  parameter int unsigned SKIP_EMPTY      = 1,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  floo_dma_req_serializer_if.slave bus
);
  localparam int unsigned c_BE_W  = DATA_WIDTH / 8;
  localparam int unsigned c_IDX_W = $clog2(NUM_WORDS);
  localparam int unsigned c_PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned c_CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_SEND = 1'b1;

  logic [0:0]                      state_q, state_d;
  logic                            req_wen_q;
  logic [NUM_WORDS*c_BE_W-1:0]     req_be_q;
  logic [NUM_WORDS*DATA_WIDTH-1:0] req_data_q;
  logic [ADDR_WIDTH-1:0]           req_addr_q;
  logic [META_WIDTH-1:0]           req_meta_q;
  logic [NUM_WORDS-1:0]            mask_q;

  logic [NUM_WORDS-1:0]            w_new_mask, w_rest;
  logic [c_IDX_W-1:0]              w_idx;
  logic                            w_is_last, w_flit_hs, w_last_hs, w_accept;

  logic [NUM_WORDS-1:0]            fifo_q [MAX_OUTSTANDING];
  logic [c_PTR_W-1:0]              wr_ptr_q, rd_ptr_q;
  logic [c_CNT_W-1:0]              cnt_q;
  logic                            w_full, w_empty, w_push, w_pop;
  logic [NUM_WORDS-1:0]            w_head;

  logic [NUM_WORDS-1:0]            filled_q;
  logic [NUM_WORDS*DATA_WIDTH-1:0] wdata_q;
  logic                            wrsp_valid_q;
  logic [NUM_WORDS-1:0]            w_todo, w_fill_next;
  logic [c_IDX_W-1:0]              w_widx;
  logic                            w_rsp_hs;

  function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + c_PTR_W'(1);
  endfunction

  // An all-empty request still emits word 0 so the burst is never silent.
  always_comb begin
    w_new_mask = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      w_new_mask[k] = (SKIP_EMPTY == 0) || (bus.req_be_i[k*c_BE_W +: c_BE_W] != '0);
    end
    if (w_new_mask == '0) w_new_mask[0] = 1'b1;
  end

  always_comb begin
    w_idx = '0;
    for (int k = NUM_WORDS - 1; k >= 0; k--) begin
      if (mask_q[k]) w_idx = c_IDX_W'(k);
    end
  end

  assign w_rest    = mask_q & ~(NUM_WORDS'(1) << w_idx);
  assign w_is_last = (w_rest == '0);
  assign w_flit_hs = (state_q == c_SEND) && bus.flit_ready_i;
  assign w_last_hs = w_flit_hs && w_is_last;

  assign w_full  = (cnt_q == c_CNT_W'(MAX_OUTSTANDING));
  assign w_empty = (cnt_q == '0);

  // Full check uses the registered count: a same-cycle pop does not free a slot.
  assign bus.req_ready_o = ((state_q == c_IDLE) || w_last_hs) && (bus.req_wen_i || !w_full);
  assign w_accept        = bus.req_valid_i && bus.req_ready_o;
  assign w_push          = w_accept && !bus.req_wen_i;
  assign w_pop           = wrsp_valid_q && bus.wrsp_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= c_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (w_accept) state_d = c_SEND;
      c_SEND:  if (w_last_hs) state_d = w_accept ? c_SEND : c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    bus.flit_valid_o = (state_q == c_SEND);
    bus.flit_wen_o   = req_wen_q;
    bus.flit_be_o    = req_be_q[w_idx*c_BE_W +: c_BE_W];
    bus.flit_data_o  = req_data_q[w_idx*DATA_WIDTH +: DATA_WIDTH];
    bus.flit_addr_o  = req_addr_q + ADDR_WIDTH'(w_idx);
    bus.flit_meta_o  = req_meta_q;
    bus.flit_last_o  = w_is_last;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mask_q     <= '0;
      req_wen_q  <= 1'b0;
      req_be_q   <= '0;
      req_data_q <= '0;
      req_addr_q <= '0;
      req_meta_q <= '0;
    end else if (w_accept) begin
      mask_q     <= w_new_mask;
      req_wen_q  <= bus.req_wen_i;
      req_be_q   <= bus.req_be_i;
      req_data_q <= bus.req_data_i;
      req_addr_q <= bus.req_addr_i;
      req_meta_q <= bus.req_meta_i;
    end else if (w_flit_hs) begin
      mask_q <= w_rest;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (w_push) begin
        fifo_q[wr_ptr_q] <= w_new_mask;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (w_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({w_push, w_pop})
        2'b10:   cnt_q <= cnt_q + c_CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - c_CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign w_head = fifo_q[rd_ptr_q];
  assign w_todo = w_head & ~filled_q;

  always_comb begin
    w_widx = '0;
    for (int k = NUM_WORDS - 1; k >= 0; k--) begin
      if (w_todo[k]) w_widx = c_IDX_W'(k);
    end
  end

  assign w_fill_next     = filled_q | (NUM_WORDS'(1) << w_widx);
  assign bus.rsp_ready_o = !w_empty && !wrsp_valid_q;
  assign w_rsp_hs        = bus.rsp_ready_o && bus.rsp_valid_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || w_pop) begin
      filled_q     <= '0;
      wdata_q      <= '0;
      wrsp_valid_q <= 1'b0;
    end else if (w_rsp_hs) begin
      wdata_q[w_widx*DATA_WIDTH +: DATA_WIDTH] <= bus.rsp_data_i;
      filled_q                                 <= w_fill_next;
      if (w_fill_next == w_head) wrsp_valid_q <= 1'b1;
    end
  end

  assign bus.wrsp_valid_o  = wrsp_valid_q;
  assign bus.wrsp_data_o   = wdata_q;
  assign bus.wrsp_strb_o   = w_empty ? '0 : w_head;
  assign bus.outstanding_o = cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_floo_dma_req_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_floo_dma_req_serializer
// Brief    : Self-checking bench with a queue-based model of the serializer.
// Revision : 1.0
// ============================================================================
module tb_floo_dma_req_serializer;
  localparam int NW = 4;
  localparam int DW = 32;
  localparam int AW = 18;
  localparam int MW = 8;
  localparam int MO = 4;
  localparam int BW = DW / 8;

  typedef struct {
    logic          wen;
    logic [BW-1:0] be;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic [MW-1:0] meta;
    logic          last;
  } flit_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  floo_dma_req_serializer_if #(.NUM_WORDS(NW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .META_WIDTH(MW), .MAX_OUTSTANDING(MO)) bus ();
  floo_dma_req_serializer_if #(.NUM_WORDS(NW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .META_WIDTH(MW), .MAX_OUTSTANDING(MO)) bus_ns ();

  floo_dma_req_serializer #(.NUM_WORDS(NW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .META_WIDTH(MW), .SKIP_EMPTY(1), .MAX_OUTSTANDING(MO))
    u_dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  floo_dma_req_serializer #(.NUM_WORDS(NW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .META_WIDTH(MW), .SKIP_EMPTY(0), .MAX_OUTSTANDING(MO))
    u_dut_ns (.clk_i(clk), .rst_i(rst), .bus(bus_ns));

  flit_t             fq[$];
  flit_t             flog[$];
  logic [NW-1:0]     rdq[$];
  logic [DW-1:0]     rw[$];
  logic [DW-1:0]     rlog[$];
  int                out_cnt, pend_rsp, total, bad, whs_cnt, b2b_cnt;
  int                fr_mode, rsp_on, wr_rand;
  bit                acc_seen;
  logic [NW*DW-1:0]  last_wdata;
  logic [NW-1:0]     last_wstrb;

  task automatic chk(string name, logic [NW*DW-1:0] act, logic [NW*DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NW-1:0] mdl_mask(logic [NW*BW-1:0] be);
    logic [NW-1:0] m = '0;
    for (int k = 0; k < NW; k++) m[k] = (be[k*BW +: BW] != '0);
    if (m == '0) m = 1;
    return m;
  endfunction

  function automatic logic [NW*DW-1:0] assemble(logic [NW-1:0] m);
    logic [NW*DW-1:0] r = '0;
    int j = 0;
    for (int k = 0; k < NW; k++) begin
      if (m[k]) begin
        r[k*DW +: DW] = rw[j];
        j++;
      end
    end
    return r;
  endfunction

  task automatic model_accept(bit wen, logic [NW*BW-1:0] be, logic [NW*DW-1:0] d,
                              logic [AW-1:0] a, logic [MW-1:0] meta);
    logic [NW-1:0] m = mdl_mask(be);
    int hi = 0;
    flit_t f;
    for (int k = 0; k < NW; k++) if (m[k]) hi = k;
    for (int k = 0; k < NW; k++) begin
      if (m[k]) begin
        f.wen = wen; f.be = be[k*BW +: BW]; f.data = d[k*DW +: DW];
        f.addr = a + AW'(k); f.meta = meta; f.last = (k == hi);
        fq.push_back(f);
      end
    end
    if (!wen) begin
      rdq.push_back(m);
      out_cnt++;
    end
  endtask

  task automatic compare_outputs();
    bit ev = (rdq.size() > 0) && (rw.size() == $countones(rdq[0]));
    chk("flit_valid", bus.flit_valid_o, fq.size() != 0);
    if (bus.flit_valid_o && fq.size() != 0) begin
      chk("flit_addr", bus.flit_addr_o, fq[0].addr);
      chk("flit_data", bus.flit_data_o, fq[0].data);
      chk("flit_be",   bus.flit_be_o,   fq[0].be);
      chk("flit_wen",  bus.flit_wen_o,  fq[0].wen);
      chk("flit_meta", bus.flit_meta_o, fq[0].meta);
      chk("flit_last", bus.flit_last_o, fq[0].last);
    end
    chk("outstanding", bus.outstanding_o, out_cnt);
    chk("wrsp_valid", bus.wrsp_valid_o, ev);
    chk("rsp_ready", bus.rsp_ready_o, (out_cnt > 0) && !ev);
    chk("wrsp_strb", bus.wrsp_strb_o, (rdq.size() > 0) ? rdq[0] : '0);
    if (ev) chk("wrsp_data", bus.wrsp_data_o, assemble(rdq[0]));
  endtask

  // One clock: drive sink/responder, sample handshakes, advance model, compare.
  task automatic step();
    bit acc, fhs, rhs, whs, exp_rdy, wen;
    logic [NW*BW-1:0] be;
    logic [NW*DW-1:0] d, wd;
    logic [AW-1:0] a;
    logic [MW-1:0] meta;
    logic [DW-1:0] rd;
    logic [NW-1:0] ws;
    flit_t f;
    case (fr_mode)
      0:       bus.flit_ready_i = 1'b1;
      1:       bus.flit_ready_i = 1'($urandom % 2);
      2:       bus.flit_ready_i = ~bus.flit_ready_i;
      default: bus.flit_ready_i = 1'b0;
    endcase
    bus.rsp_valid_i  = (rsp_on != 0) && (pend_rsp > 0) && ($urandom % 4 != 0);
    bus.rsp_data_i   = $urandom;
    bus.wrsp_ready_i = (wr_rand != 0) ? 1'($urandom % 2) : 1'b1;
    #1;
    acc = bus.req_valid_i && bus.req_ready_o;
    fhs = bus.flit_valid_o && bus.flit_ready_i;
    rhs = bus.rsp_valid_i && bus.rsp_ready_o;
    whs = bus.wrsp_valid_o && bus.wrsp_ready_i;
    wen = bus.req_wen_i; be = bus.req_be_i; d = bus.req_data_i;
    a = bus.req_addr_i; meta = bus.req_meta_i; rd = bus.rsp_data_i;
    wd = bus.wrsp_data_o; ws = bus.wrsp_strb_o;
    exp_rdy = ((fq.size() == 0) || (fhs && fq[0].last)) && (wen || out_cnt < MO);
    chk("req_ready", bus.req_ready_o, exp_rdy);
    acc_seen = acc;
    @(posedge clk);
    if (rst) begin
      fq.delete(); rdq.delete(); rw.delete();
      out_cnt = 0; pend_rsp = 0;
    end else begin
      if (fhs && fq.size() > 0) begin
        f = fq.pop_front();
        flog.push_back(f);
        if (!f.wen) pend_rsp++;
        if (acc && f.last) b2b_cnt++;
      end
      if (rhs) begin
        rw.push_back(rd); rlog.push_back(rd); pend_rsp--;
      end
      if (whs && rdq.size() > 0) begin
        last_wdata = wd; last_wstrb = ws;
        for (int k = 0; k < $countones(rdq[0]); k++) void'(rw.pop_front());
        void'(rdq.pop_front());
        out_cnt--; whs_cnt++;
      end
      if (acc) model_accept(wen, be, d, a, meta);
    end
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic send_req(bit wen, logic [NW*BW-1:0] be, logic [NW*DW-1:0] d,
                          logic [AW-1:0] a, logic [MW-1:0] meta);
    bus.req_valid_i = 1'b1; bus.req_wen_i = wen; bus.req_be_i = be;
    bus.req_data_i = d; bus.req_addr_i = a; bus.req_meta_i = meta;
    for (int i = 0; i < 500; i++) begin
      step();
      if (acc_seen) return;
    end
    total++; bad++;
    $display("FAIL req_accept_timeout: got no accept expected accept within 500 cycles");
    bus.req_valid_i = 1'b0;
  endtask

  task automatic wait_flits();
    bus.req_valid_i = 1'b0;
    for (int i = 0; i < 1000 && fq.size() > 0; i++) step();
    if (fq.size() > 0) begin
      total++; bad++;
      $display("FAIL flit_timeout: got %0d pending expected 0", fq.size());
    end
  endtask

  task automatic drain();
    bus.req_valid_i = 1'b0;
    rsp_on = 1;
    for (int i = 0; i < 3000 && (fq.size() > 0 || rdq.size() > 0); i++) step();
    if (fq.size() > 0 || rdq.size() > 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d flits %0d reads expected 0", fq.size(), rdq.size());
    end
    rsp_on = 0;
  endtask

  function automatic logic [NW*DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lpos, whs0, b0;
    logic [NW*BW-1:0] be;
    logic [AW-1:0] a;
    total = 0; bad = 0; out_cnt = 0; pend_rsp = 0; whs_cnt = 0; b2b_cnt = 0;
    fr_mode = 0; rsp_on = 0; wr_rand = 0;
    bus.req_valid_i = 0; bus.req_wen_i = 0; bus.req_be_i = '0; bus.req_data_i = '0;
    bus.req_addr_i = '0; bus.req_meta_i = '0; bus.flit_ready_i = 0;
    bus.rsp_valid_i = 0; bus.rsp_data_i = '0; bus.wrsp_ready_i = 0;
    bus_ns.req_valid_i = 0; bus_ns.req_wen_i = 1; bus_ns.req_be_i = '0;
    bus_ns.req_data_i = 128'h3333_3333_2222_2222_1111_1111_0000_0000;
    bus_ns.req_addr_i = 18'h5; bus_ns.req_meta_i = 8'h5A; bus_ns.flit_ready_i = 1;
    bus_ns.rsp_valid_i = 0; bus_ns.rsp_data_i = '0; bus_ns.wrsp_ready_i = 1;
    rst = 1'b1;
    step(); step();
    chk("rst_flit_valid", bus.flit_valid_o, 1'b0);
    chk("rst_wrsp_valid", bus.wrsp_valid_o, 1'b0);
    chk("rst_rsp_ready", bus.rsp_ready_o, 1'b0);
    chk("rst_outstanding", bus.outstanding_o, 0);
    chk("rst_wrsp_data", bus.wrsp_data_o, '0);
    chk("rst_wrsp_strb", bus.wrsp_strb_o, '0);
    rst = 1'b0;
    step();

    // Empty write with SKIP_EMPTY=0 still produces a full burst.
    bus_ns.req_valid_i = 1'b1;
    #1;
    chk("ns_req_ready", bus_ns.req_ready_o, 1'b1);
    step();
    bus_ns.req_valid_i = 1'b0;
    n = 0; lpos = -1;
    for (int i = 0; i < 8; i++) begin
      if (bus_ns.flit_valid_o) begin
        n++;
        if (bus_ns.flit_last_o) lpos = n;
      end
      step();
    end
    chk("ns_flit_count", n, 4);
    chk("ns_last_pos", lpos, 4);

    // Full write burst.
    flog.delete(); whs0 = whs_cnt;
    send_req(1'b1, 16'hFFFF, {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000},
             18'h10, 8'h11);
    drain();
    chk("wr_flit_count", flog.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("wr_addr", flog[i].addr, 18'h10 + 18'(i));
      chk("wr_data", flog[i].data, 32'hA000_0000 + 32'(i));
      chk("wr_last", flog[i].last, i == 3);
    end
    chk("wr_no_wrsp", whs_cnt - whs0, 0);

    // Sparse read.
    flog.delete(); rlog.delete();
    send_req(1'b0, 16'h0F0F, rnd_data(), 18'h20, 8'h22);
    drain();
    chk("rd_flit_count", flog.size(), 2);
    chk("rd_addr0", flog[0].addr, 18'h20);
    chk("rd_addr1", flog[1].addr, 18'h22);
    chk("rd_wstrb", last_wstrb, 4'b0101);
    chk("rd_wdata", last_wdata, {32'h0, rlog[1], 32'h0, rlog[0]});

    // All-zero write.
    flog.delete();
    send_req(1'b1, 16'h0000, {32'h4, 32'h3, 32'h2, 32'h1}, 18'h30, 8'h33);
    drain();
    chk("zero_flit_count", flog.size(), 1);
    chk("zero_be", flog[0].be, 4'h0);
    chk("zero_last", flog[0].last, 1'b1);
    chk("zero_data", flog[0].data, 32'h1);

    // Address wrap.
    flog.delete();
    send_req(1'b1, 16'hFFFF, rnd_data(), 18'h3FFFE, 8'h44);
    drain();
    chk("wrap_a0", flog[0].addr, 18'h3FFFE);
    chk("wrap_a1", flog[1].addr, 18'h3FFFF);
    chk("wrap_a2", flog[2].addr, 18'h00000);
    chk("wrap_a3", flog[3].addr, 18'h00001);

    // Back-to-back bursts with a toggling sink.
    fr_mode = 2; b0 = b2b_cnt;
    for (int i = 0; i < 4; i++) send_req(1'b1, 16'hFFFF, rnd_data(), 18'(i * 8), 8'(i));
    drain();
    chk("b2b_events", (b2b_cnt - b0) >= 3, 1'b1);
    fr_mode = 0;

    // Read-mask FIFO full.
    for (int i = 0; i < 4; i++) send_req(1'b0, 16'hFFFF, rnd_data(), 18'(64 + i * 4), 8'(i));
    wait_flits();
    chk("full_outstanding", bus.outstanding_o, 4);
    bus.req_valid_i = 1'b1; bus.req_wen_i = 1'b0;
    step(); step();
    chk("full_rd_blocked", bus.req_ready_o, 1'b0);
    send_req(1'b1, 16'hFFFF, rnd_data(), 18'h100, 8'h77);
    chk("full_wr_accept", acc_seen, 1'b1);
    wait_flits();
    whs0 = whs_cnt; rsp_on = 1;
    for (int i = 0; i < 200 && whs_cnt == whs0; i++) step();
    rsp_on = 0;
    chk("one_wrsp", whs_cnt - whs0, 1);
    chk("outstanding_3", bus.outstanding_o, 3);
    send_req(1'b0, 16'hFFFF, rnd_data(), 18'h200, 8'h88);
    chk("rd5_accept", acc_seen, 1'b1);
    drain();

    // Reset in the middle of a burst with reads outstanding.
    send_req(1'b0, 16'hFFFF, rnd_data(), 18'h300, 8'h01);
    send_req(1'b0, 16'hFFFF, rnd_data(), 18'h310, 8'h02);
    send_req(1'b1, 16'hFFFF, rnd_data(), 18'h320, 8'h03);
    bus.req_valid_i = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_flit_valid", bus.flit_valid_o, 1'b0);
    chk("midrst_wrsp_valid", bus.wrsp_valid_o, 1'b0);
    chk("midrst_outstanding", bus.outstanding_o, 0);

    // Randomized traffic.
    fr_mode = 1; wr_rand = 1; rsp_on = 1;
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < NW; k++) begin
        case ($urandom % 3)
          0:       be[k*BW +: BW] = '0;
          1:       be[k*BW +: BW] = '1;
          default: be[k*BW +: BW] = 4'($urandom);
        endcase
      end
      a = ($urandom % 4 == 0) ? 18'h3FFFC + 18'($urandom % 4) : 18'($urandom);
      send_req(1'($urandom % 2), be, rnd_data(), a, 8'($urandom));
      rsp_on = 1;
      if ($urandom % 5 == 0) begin
        bus.req_valid_i = 1'b0;
        for (int j = 0; j < int'($urandom % 4); j++) step();
      end
    end
    drain();
    wr_rand = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/floo_dma_req_serializer.md
Name: floo_dma_req_serializer

Overview:
- Splits one wide DMA-side TCDM request of NumWords words into a stream of narrow, word-sized FlooNoC-style request flits.
  - Each flit carries a per-word address and a last flag.
- Reassembles the narrow read responses back into one wide response.
- Optionally skips words whose byte-enables are all zero.
- Sits between a group DMA frontend and the narrow remote-group TCDM request/response ports.

Parameters:
- NumWords, 4, words per wide request (power of two, >=2)
- DataWidth, 32, narrow word width in bits; BeW = DataWidth/8
- AddrWidth, 18, word-address width of tgt_addr
- MetaWidth, 8, opaque meta/id field copied to every flit
- SkipEmpty, 1, 1: words with all-zero be are not sent
- MaxOutstanding, 4, depth of the read-mask FIFO (power of two)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  1  wide request valid
- req_ready_o  out  1  wide request ready
- req_wen_i  in  1  1 = write
- req_be_i  in  NumWords*BeW  byte enables; word k = bits [k*BeW +: BeW]
- req_data_i  in  NumWords*DataWidth  write data
- req_addr_i  in  AddrWidth  word address of word 0
- req_meta_i  in  MetaWidth  meta id
- flit_valid_o  out  1  narrow flit valid
- flit_ready_i  in  1  narrow flit ready
- flit_wen_o  out  1  write flag
- flit_be_o  out  BeW  byte enables
- flit_data_o  out  DataWidth  data
- flit_addr_o  out  AddrWidth  word address
- flit_meta_o  out  MetaWidth  meta id
- flit_last_o  out  1  final flit of this wide request
- rsp_valid_i  in  1  narrow read response valid (in order)
- rsp_ready_o  out  1  narrow response ready
- rsp_data_i  in  DataWidth  read data
- wrsp_valid_o  out  1  wide response valid
- wrsp_ready_i  in  1  wide response ready
- wrsp_data_o  out  NumWords*DataWidth  assembled read data
- wrsp_strb_o  out  NumWords  words that carry data
- outstanding_o  out  $clog2(MaxOutstanding)+1  reads awaiting wide response

Behaviour:
- Reset: synchronous on rst_i = 1.
  - State IDLE; mask FIFO emptied.
  - flit_valid_o, wrsp_valid_o, rsp_ready_o, outstanding_o = 0.
  - wrsp_data_o and wrsp_strb_o = 0.
  - Reset mid-burst drops the in-flight request and all collected words.
- Send mask: word k is included if SkipEmpty = 0 or its be != 0.
  - An all-zero mask is replaced by a mask of word 0 only, so at least one flit is always sent.
- Accept rule: req_ready_o = (state == IDLE or a last-flit handshake happens this cycle) and (req_wen_i or FIFO not full).
  - This makes req_ready_o combinational on flit_ready_i.
  - A full FIFO blocks reads even if the FIFO pops in the same cycle.
  - Writes are never blocked by the FIFO.
- On accept:
  - The request and its mask are registered and the state moves to SEND.
  - Reads push the mask into the FIFO.
- SEND state:
  - flit_valid_o = 1 starting the cycle after accept (latency 1).
  - Flit k takes the data and be of word k.
  - flit_addr_o = req_addr + k, modulo 2^AddrWidth (wraps).
  - Flits go out for ascending set mask bits; flit_last_o = 1 on the highest set bit.
  - The flit payload holds stable while flit_valid_o = 1 and flit_ready_i = 0.
  - A last handshake goes to IDLE, or straight to SEND with the new request if one is accepted in the same cycle (back-to-back, no bubble).
- Deserializer:
  - rsp_ready_o = FIFO not empty and wrsp_valid_o = 0.
  - Each accepted response is written into the next set bit of the FIFO head mask, in ascending order.
  - After the final set bit is written, wrsp_valid_o = 1 on the next cycle.
  - wrsp_strb_o = head mask; unfilled words = 0.
  - wrsp holds stable until wrsp_ready_i; the handshake pops the FIFO and clears the collected data.
- outstanding_o = FIFO occupancy; a push and a pop in the same cycle leave it unchanged.
- Writes produce no wide response.

Test Plan:
- Write, NumWords=4, be=16'hFFFF, addr=0x10, data words A0..A3 -> 4 flits, addr 0x10..0x13, data A0..A3, last on the 4th only, no wrsp.
- Read, be=16'h0F0F, SkipEmpty=1 -> 2 flits at addr+0 and addr+2; responses D0,D1 -> wrsp_data = {0,D1,0,D0}, wrsp_strb = 4'b0101.
- Write with be=0 -> exactly 1 flit, word 0, be=0, last=1; with SkipEmpty=0 the same request gives 4 flits.
- addr=0x3FFFE, full mask -> flit addresses 0x3FFFE, 0x3FFFF, 0x00000, 0x00001.
- flit_ready_i toggling 1/0 with back-to-back requests -> payload stable while stalled, no bubble between bursts, req_ready_o rises in the same cycle as the last handshake.
- 4 reads with no responses -> outstanding_o = 4, a 5th read is stalled while a write is still accepted; one wrsp handshake -> outstanding_o = 3 and the 5th read is accepted.
- Reset asserted mid-burst -> all valids 0 the next cycle, outstanding_o = 0.
